// File: rtl/rop_dcr_ctrl.sv
// rop_dcr_ctrl: ROP DCR staging registers with idle-gated atomic commit to the active image
package rop_types;
  localparam int ROP_DEPTH_FUNC_BITS = 3;
  localparam int ROP_STENCIL_OP_BITS = 3;
  localparam int ROP_BLEND_MODE_BITS = 3;
  localparam int ROP_BLEND_FUNC_BITS = 4;
  localparam int ROP_LOGIC_OP_BITS   = 4;
  localparam logic [ROP_DEPTH_FUNC_BITS-1:0] ROP_DEPTH_FUNC_ALWAYS = 3'd7;
  localparam logic [ROP_STENCIL_OP_BITS-1:0] ROP_STENCIL_OP_KEEP   = 3'd0;
  localparam logic [ROP_BLEND_MODE_BITS-1:0] ROP_BLEND_MODE_ADD    = 3'd0;
  localparam logic [ROP_BLEND_FUNC_BITS-1:0] ROP_BLEND_FUNC_ZERO   = 4'd0;
  localparam logic [ROP_BLEND_FUNC_BITS-1:0] ROP_BLEND_FUNC_ONE    = 4'd1;
  localparam logic [ROP_LOGIC_OP_BITS-1:0]   ROP_LOGIC_OP_COPY     = 4'd3;
  typedef struct packed {
    logic [7:0] a;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgba_t;
  typedef struct packed {
    logic [31:0]                    cbuf_addr;
    logic [31:0]                    cbuf_pitch;
    logic [31:0]                    cbuf_mask;
    logic [31:0]                    zbuf_addr;
    logic [31:0]                    zbuf_pitch;
    logic [ROP_DEPTH_FUNC_BITS-1:0] depth_func;
    logic                           depth_writemask;
    logic [ROP_DEPTH_FUNC_BITS-1:0] stencil_front_func;
    logic [ROP_DEPTH_FUNC_BITS-1:0] stencil_back_func;
    logic [ROP_STENCIL_OP_BITS-1:0] stencil_front_zpass;
    logic [ROP_STENCIL_OP_BITS-1:0] stencil_back_zpass;
    logic [ROP_STENCIL_OP_BITS-1:0] stencil_front_zfail;
    logic [ROP_STENCIL_OP_BITS-1:0] stencil_back_zfail;
    logic [ROP_STENCIL_OP_BITS-1:0] stencil_front_fail;
    logic [ROP_STENCIL_OP_BITS-1:0] stencil_back_fail;
    logic [7:0]                     stencil_front_ref;
    logic [7:0]                     stencil_back_ref;
    logic [7:0]                     stencil_front_mask;
    logic [7:0]                     stencil_back_mask;
    logic [ROP_BLEND_MODE_BITS-1:0] blend_mode_rgb;
    logic [ROP_BLEND_MODE_BITS-1:0] blend_mode_a;
    logic [ROP_BLEND_FUNC_BITS-1:0] blend_src_rgb;
    logic [ROP_BLEND_FUNC_BITS-1:0] blend_src_a;
    logic [ROP_BLEND_FUNC_BITS-1:0] blend_dst_rgb;
    logic [ROP_BLEND_FUNC_BITS-1:0] blend_dst_a;
    rgba_t                          blend_const;
    logic [ROP_LOGIC_OP_BITS-1:0]   logic_op;
  } rop_dcrs_t;
  function automatic rop_dcrs_t dcr_defaults();
    rop_dcrs_t s;
    s = '0;
    s.cbuf_mask           = '1;
    s.depth_func          = ROP_DEPTH_FUNC_ALWAYS;
    s.stencil_front_func  = ROP_DEPTH_FUNC_ALWAYS;
    s.stencil_back_func   = ROP_DEPTH_FUNC_ALWAYS;
    s.stencil_front_zpass = ROP_STENCIL_OP_KEEP;
    s.stencil_back_zpass  = ROP_STENCIL_OP_KEEP;
    s.stencil_front_zfail = ROP_STENCIL_OP_KEEP;
    s.stencil_back_zfail  = ROP_STENCIL_OP_KEEP;
    s.stencil_front_fail  = ROP_STENCIL_OP_KEEP;
    s.stencil_back_fail   = ROP_STENCIL_OP_KEEP;
    s.stencil_front_mask  = 8'hFF;
    s.stencil_back_mask   = 8'hFF;
    s.blend_mode_rgb      = ROP_BLEND_MODE_ADD;
    s.blend_mode_a        = ROP_BLEND_MODE_ADD;
    s.blend_src_rgb       = ROP_BLEND_FUNC_ONE;
    s.blend_src_a         = ROP_BLEND_FUNC_ONE;
    s.blend_dst_rgb       = ROP_BLEND_FUNC_ZERO;
    s.blend_dst_a         = ROP_BLEND_FUNC_ZERO;
    s.logic_op            = ROP_LOGIC_OP_COPY;
    return s;
  endfunction
endpackage

module rop_dcr_ctrl
  import rop_types::*;
#(
  parameter int                       DCR_ADDR_BITS = 12,
  parameter logic [DCR_ADDR_BITS-1:0] DCR_BASE      = 'h100
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     dcr_wr_valid,
  output logic                     dcr_wr_ready,
  input  logic [DCR_ADDR_BITS-1:0] dcr_wr_addr,
  input  logic [31:0]              dcr_wr_data,
  input  logic [DCR_ADDR_BITS-1:0] dcr_rd_addr,
  output logic [31:0]              dcr_rd_data,
  input  logic                     commit,
  input  logic                     rop_idle,
  output rop_dcrs_t                dcrs,
  output logic                     dcrs_changed,
  output logic                     commit_pending
);
  typedef enum logic {S_IDLE, S_PENDING} state_t;
  localparam rop_dcrs_t DEFAULTS = dcr_defaults();
  localparam logic [DCR_ADDR_BITS-1:0] LAST_IDX = DCR_ADDR_BITS'(16);

  function automatic rop_dcrs_t dcr_write(rop_dcrs_t s, logic [4:0] idx, logic [31:0] d);
    rop_dcrs_t r;
    r = s;
    case (idx)
      5'd0:  r.cbuf_addr      = d;
      5'd1:  r.cbuf_pitch     = d;
      5'd2:  r.cbuf_mask      = d;
      5'd3:  r.zbuf_addr      = d;
      5'd4:  r.zbuf_pitch     = d;
      5'd5:  r.depth_func     = d[ROP_DEPTH_FUNC_BITS-1:0];
      5'd6:  r.depth_writemask = d[0];
      5'd7:  {r.stencil_back_func, r.stencil_front_func} = {d[16 +: ROP_DEPTH_FUNC_BITS], d[ROP_DEPTH_FUNC_BITS-1:0]};
      5'd8:  {r.stencil_back_zpass, r.stencil_front_zpass} = {d[16 +: ROP_STENCIL_OP_BITS], d[ROP_STENCIL_OP_BITS-1:0]};
      5'd9:  {r.stencil_back_zfail, r.stencil_front_zfail} = {d[16 +: ROP_STENCIL_OP_BITS], d[ROP_STENCIL_OP_BITS-1:0]};
      5'd10: {r.stencil_back_fail, r.stencil_front_fail} = {d[16 +: ROP_STENCIL_OP_BITS], d[ROP_STENCIL_OP_BITS-1:0]};
      5'd11: {r.stencil_back_ref, r.stencil_front_ref} = {d[23:16], d[7:0]};
      5'd12: {r.stencil_back_mask, r.stencil_front_mask} = {d[23:16], d[7:0]};
      5'd13: {r.blend_mode_a, r.blend_mode_rgb} = {d[16 +: ROP_BLEND_MODE_BITS], d[ROP_BLEND_MODE_BITS-1:0]};
      5'd14: {r.blend_dst_a, r.blend_dst_rgb, r.blend_src_a, r.blend_src_rgb} =
               {d[24 +: ROP_BLEND_FUNC_BITS], d[16 +: ROP_BLEND_FUNC_BITS], d[8 +: ROP_BLEND_FUNC_BITS], d[ROP_BLEND_FUNC_BITS-1:0]};
      5'd15: r.blend_const    = d;
      5'd16: r.logic_op       = d[ROP_LOGIC_OP_BITS-1:0];
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] dcr_read(rop_dcrs_t s, logic [4:0] idx);
    case (idx)
      5'd0:  return s.cbuf_addr;
      5'd1:  return s.cbuf_pitch;
      5'd2:  return s.cbuf_mask;
      5'd3:  return s.zbuf_addr;
      5'd4:  return s.zbuf_pitch;
      5'd5:  return 32'(s.depth_func);
      5'd6:  return 32'(s.depth_writemask);
      5'd7:  return {16'(s.stencil_back_func), 16'(s.stencil_front_func)};
      5'd8:  return {16'(s.stencil_back_zpass), 16'(s.stencil_front_zpass)};
      5'd9:  return {16'(s.stencil_back_zfail), 16'(s.stencil_front_zfail)};
      5'd10: return {16'(s.stencil_back_fail), 16'(s.stencil_front_fail)};
      5'd11: return {8'h0, s.stencil_back_ref, 8'h0, s.stencil_front_ref};
      5'd12: return {8'h0, s.stencil_back_mask, 8'h0, s.stencil_front_mask};
      5'd13: return {16'(s.blend_mode_a), 16'(s.blend_mode_rgb)};
      5'd14: return {8'(s.blend_dst_a), 8'(s.blend_dst_rgb), 8'(s.blend_src_a), 8'(s.blend_src_rgb)};
      5'd15: return s.blend_const;
      5'd16: return 32'(s.logic_op);
      default: return '0;
    endcase
  endfunction

  state_t                   state_q;
  rop_dcrs_t                stg_q, stg_d, act_q;
  logic                     chg_q, wr_en, copy, wr_hit, rd_hit;
  logic [31:0]              rd_q, rd_d;
  logic [DCR_ADDR_BITS-1:0] wr_off, rd_off;

  assign wr_off = dcr_wr_addr - DCR_BASE;
  assign rd_off = dcr_rd_addr - DCR_BASE;
  assign wr_hit = dcr_wr_addr >= DCR_BASE && wr_off <= LAST_IDX;
  assign rd_hit = dcr_rd_addr >= DCR_BASE && rd_off <= LAST_IDX;

  always_comb begin
    wr_en = dcr_wr_valid && state_q == S_IDLE && wr_hit;
    stg_d = wr_en ? dcr_write(stg_q, wr_off[4:0], dcr_wr_data) : stg_q;
    rd_d  = rd_hit ? dcr_read(stg_q, rd_off[4:0]) : '0;
    copy  = rop_idle && (state_q == S_PENDING || commit);
  end

  // stg_d carries any same-cycle write, so an IDLE commit copies the post-write image
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      stg_q   <= DEFAULTS;
      act_q   <= DEFAULTS;
      chg_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      stg_q   <= stg_d;
      rd_q    <= rd_d;
      chg_q   <= copy;
      if (copy) act_q <= stg_d;
      state_q <= (state_q == S_IDLE && commit && !rop_idle) ? S_PENDING :
                 (state_q == S_PENDING && rop_idle) ? S_IDLE : state_q;
    end
  end

  assign dcr_wr_ready   = state_q == S_IDLE;
  assign commit_pending = state_q == S_PENDING;
  assign dcr_rd_data    = rd_q;
  assign dcrs           = act_q;
  assign dcrs_changed   = chg_q;
endmodule

// File: tb/tb_rop_dcr_ctrl.sv
// tb_rop_dcr_ctrl: directed checks of staging, commit, pending, bypass and range handling
module tb_rop_dcr_ctrl;
  localparam logic [11:0] BASE = 12'h100;
  logic        clk = 0, reset = 1, dcr_wr_valid = 0, commit = 0, rop_idle = 1;
  logic        dcr_wr_ready, dcrs_changed, commit_pending;
  logic [11:0] dcr_wr_addr = '0, dcr_rd_addr = '0;
  logic [31:0] dcr_wr_data = '0, dcr_rd_data;
  rop_types::rop_dcrs_t dcrs, exp_def;
  int n_cmp = 0, n_err = 0;

  rop_dcr_ctrl #(.DCR_ADDR_BITS(12), .DCR_BASE(BASE)) dut (
    .clk(clk), .reset(reset), .dcr_wr_valid(dcr_wr_valid), .dcr_wr_ready(dcr_wr_ready),
    .dcr_wr_addr(dcr_wr_addr), .dcr_wr_data(dcr_wr_data), .dcr_rd_addr(dcr_rd_addr),
    .dcr_rd_data(dcr_rd_data), .commit(commit), .rop_idle(rop_idle), .dcrs(dcrs),
    .dcrs_changed(dcrs_changed), .commit_pending(commit_pending)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    dcr_wr_valid = 1; dcr_wr_addr = a; dcr_wr_data = d;
    step;
    dcr_wr_valid = 0;
  endtask

  task automatic rd_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
    dcr_rd_addr = a;
    step;
    n_cmp++;
    if (dcr_rd_data !== exp) begin n_err++; $display("FAIL %s: got %h want %h", name, dcr_rd_data, exp); end
  endtask

  task automatic test_reset;
    reset = 1; dcr_rd_addr = BASE + 12'd2;
    step; step;
    n_cmp++; if (dcr_rd_data !== 32'h0) begin n_err++; $display("FAIL rst_rd: got %h want 0", dcr_rd_data); end
    reset = 0;
    step;
    n_cmp++; if (dcr_wr_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", dcr_wr_ready); end
    n_cmp++; if (commit_pending !== 1'b0) begin n_err++; $display("FAIL rst_pending: got %b want 0", commit_pending); end
    n_cmp++; if (dcrs_changed !== 1'b0) begin n_err++; $display("FAIL rst_changed: got %b want 0", dcrs_changed); end
    n_cmp++; if (dcrs !== exp_def) begin n_err++; $display("FAIL rst_dcrs: got %h want %h", dcrs, exp_def); end
    n_cmp++; if (dcr_rd_data !== 32'hFFFFFFFF) begin n_err++; $display("FAIL rst_rd2: got %h want ffffffff", dcr_rd_data); end
    rd_chk("rst_rd16", BASE + 12'd16, 32'h3);
    rd_chk("rst_rd5", BASE + 12'd5, 32'h7);
    rd_chk("rst_rd12", BASE + 12'd12, 32'h00FF00FF);
    rd_chk("rst_rd14", BASE + 12'd14, 32'h00000101);
  endtask

  task automatic test_commit_idle;
    wr(BASE, 32'h8000_0000);
    n_cmp++; if (dcrs.cbuf_addr !== 32'h0) begin n_err++; $display("FAIL pre_commit: got %h want 0", dcrs.cbuf_addr); end
    commit = 1; rop_idle = 1;
    step;
    commit = 0;
    n_cmp++; if (dcrs.cbuf_addr !== 32'h8000_0000) begin n_err++; $display("FAIL commit_addr: got %h want 80000000", dcrs.cbuf_addr); end
    n_cmp++; if (dcrs_changed !== 1'b1) begin n_err++; $display("FAIL commit_pulse: got %b want 1", dcrs_changed); end
    step;
    n_cmp++; if (dcrs_changed !== 1'b0) begin n_err++; $display("FAIL commit_pulse_end: got %b want 0", dcrs_changed); end
  endtask

  task automatic test_pending;
    wr(BASE + 12'd11, 32'h00AB_00CD);
    commit = 1; rop_idle = 0;
    step;
    commit = 0;
    for (int i = 0; i < 5; i++) begin
      dcr_wr_valid = 1; dcr_wr_addr = BASE; dcr_wr_data = 32'h1234; commit = (i == 2);
      n_cmp++; if (commit_pending !== 1'b1) begin n_err++; $display("FAIL pend_flag[%0d]: got %b want 1", i, commit_pending); end
      n_cmp++; if (dcr_wr_ready !== 1'b0) begin n_err++; $display("FAIL pend_ready[%0d]: got %b want 0", i, dcr_wr_ready); end
      n_cmp++; if (dcrs.stencil_front_ref !== 8'h00 || dcrs_changed !== 1'b0) begin
        n_err++; $display("FAIL pend_hold[%0d]: got ref %h chg %b want 00/0", i, dcrs.stencil_front_ref, dcrs_changed);
      end
      step;
    end
    dcr_wr_valid = 0; commit = 0; rop_idle = 1;
    step;
    n_cmp++; if (commit_pending !== 1'b0) begin n_err++; $display("FAIL pend_clear: got %b want 0", commit_pending); end
    n_cmp++; if (dcrs.stencil_front_ref !== 8'hCD) begin n_err++; $display("FAIL pend_front: got %h want cd", dcrs.stencil_front_ref); end
    n_cmp++; if (dcrs.stencil_back_ref !== 8'hAB) begin n_err++; $display("FAIL pend_back: got %h want ab", dcrs.stencil_back_ref); end
    n_cmp++; if (dcrs_changed !== 1'b1) begin n_err++; $display("FAIL pend_pulse: got %b want 1", dcrs_changed); end
    step;
    n_cmp++; if (dcrs_changed !== 1'b0) begin n_err++; $display("FAIL pend_merge: got %b want 0", dcrs_changed); end
    rd_chk("pend_frozen", BASE, 32'h8000_0000);
    rd_chk("pend_rd11", BASE + 12'd11, 32'h00AB_00CD);
  endtask

  task automatic test_bypass;
    dcr_wr_valid = 1; dcr_wr_addr = BASE + 12'd15; dcr_wr_data = 32'h1122_3344; commit = 1; rop_idle = 1;
    step;
    dcr_wr_valid = 0; commit = 0;
    n_cmp++; if (dcrs.blend_const !== 32'h1122_3344 || dcrs.blend_const.a !== 8'h11 || dcrs.blend_const.b !== 8'h44) begin
      n_err++; $display("FAIL bypass_const: got %h want 11223344", dcrs.blend_const);
    end
    n_cmp++; if (dcrs_changed !== 1'b1) begin n_err++; $display("FAIL bypass_pulse: got %b want 1", dcrs_changed); end
  endtask

  task automatic test_truncation;
    wr(BASE + 12'd5, 32'hFFFF_FFFF);
    rd_chk("trunc5", BASE + 12'd5, 32'h7);
    wr(BASE + 12'd6, 32'hFFFF_FFFE);
    rd_chk("trunc6", BASE + 12'd6, 32'h0);
    wr(BASE + 12'd12, 32'hFFFF_FFFF);
    rd_chk("trunc12", BASE + 12'd12, 32'h00FF_00FF);
    wr(BASE + 12'd14, 32'hFFFF_FFFF);
    rd_chk("trunc14", BASE + 12'd14, 32'h0F0F_0F0F);
    wr(BASE + 12'd7, 32'h0005_0002);
    rd_chk("stencil_func", BASE + 12'd7, 32'h0005_0002);
  endtask

  task automatic test_out_of_range;
    wr(BASE + 12'd40, 32'hDEAD_BEEF);
    wr(BASE - 12'd1, 32'hDEAD_BEEF);
    rd_chk("oor_hi", BASE + 12'd40, 32'h0);
    rd_chk("oor_lo", BASE - 12'd1, 32'h0);
    rd_chk("oor_idx17", BASE + 12'd17, 32'h0);
    rd_chk("oor_idx0", BASE, 32'h8000_0000);
    rd_chk("oor_idx16", BASE + 12'd16, 32'h3);
  endtask

  task automatic test_back_to_back;
    wr(BASE + 12'd1, 32'h0000_0400);
    wr(BASE + 12'd3, 32'h9000_0000);
    wr(BASE + 12'd4, 32'h0000_0200);
    rd_chk("b2b_1", BASE + 12'd1, 32'h0000_0400);
    rd_chk("b2b_3", BASE + 12'd3, 32'h9000_0000);
    rd_chk("b2b_4", BASE + 12'd4, 32'h0000_0200);
  endtask

  task automatic test_reset_pending;
    commit = 1; rop_idle = 0;
    step;
    commit = 0;
    n_cmp++; if (commit_pending !== 1'b1) begin n_err++; $display("FAIL rp_pending: got %b want 1", commit_pending); end
    reset = 1; rop_idle = 1;
    step;
    reset = 0;
    n_cmp++; if (commit_pending !== 1'b0) begin n_err++; $display("FAIL rp_clear: got %b want 0", commit_pending); end
    n_cmp++; if (dcrs !== exp_def) begin n_err++; $display("FAIL rp_dcrs: got %h want %h", dcrs, exp_def); end
    n_cmp++; if (dcrs_changed !== 1'b0) begin n_err++; $display("FAIL rp_pulse: got %b want 0", dcrs_changed); end
    step;
    n_cmp++; if (dcrs_changed !== 1'b0 || dcrs !== exp_def) begin n_err++; $display("FAIL rp_after: got chg %b want 0", dcrs_changed); end
    rd_chk("rp_idx0", BASE, 32'h0);
    rd_chk("rp_idx15", BASE + 12'd15, 32'h0);
  endtask

  initial begin
    exp_def = '0;
    exp_def.cbuf_mask = 32'hFFFF_FFFF;
    exp_def.depth_func = 3'd7;
    exp_def.stencil_front_func = 3'd7;
    exp_def.stencil_back_func = 3'd7;
    exp_def.stencil_front_mask = 8'hFF;
    exp_def.stencil_back_mask = 8'hFF;
    exp_def.blend_src_rgb = 4'd1;
    exp_def.blend_src_a = 4'd1;
    exp_def.logic_op = 4'd3;
    test_reset;
    test_commit_idle;
    test_pending;
    test_bypass;
    test_truncation;
    test_out_of_range;
    test_back_to_back;
    test_reset_pending;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rop_dcr_ctrl.md
# rop_dcr_ctrl

Device-configuration-register (DCR) front end for the ROP unit: it accepts 32-bit DCR writes from the host/command path and packs them into a staged `rop_types::rop_dcrs_t` image. On a commit, once the ROP pipeline reports idle, it copies the staged image atomically into the active image that drives the ROP datapath. Sits between the DCR bus and the ROP unit, and also provides registered readback of the staged registers.

## Interface
- `DCR_ADDR_BITS`, 12: DCR address width.
- `DCR_BASE`, 'h100: address of ROP register 0. Register index = `dcr_wr_addr - DCR_BASE`.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `dcr_wr_valid` in 1: write request.
- `dcr_wr_ready` out 1: write accepted when valid&ready.
- `dcr_wr_addr` in DCR_ADDR_BITS: write address.
- `dcr_wr_data` in 32: write data.
- `dcr_rd_addr` in DCR_ADDR_BITS: readback address, sampled every cycle.
- `dcr_rd_data` out 32: staged value of the register at `dcr_rd_addr`, one cycle later.
- `commit` in 1: single-cycle pulse; request staged→active copy.
- `rop_idle` in 1: ROP pipeline has no fragments in flight.
- `dcrs` out $bits(rop_dcrs_t): active image.
- `dcrs_changed` out 1: one-cycle pulse after the active image updates.
- `commit_pending` out 1: a commit is waiting for `rop_idle`.

## Operation
- Register index map (staged fields), bits from LSB:
  - 0 CBUF_ADDR
  - 1 CBUF_PITCH
  - 2 CBUF_WRITEMASK
  - 3 ZBUF_ADDR
  - 4 ZBUF_PITCH
  - 5 DEPTH_FUNC [`ROP_DEPTH_FUNC_BITS`-1:0]
  - 6 DEPTH_WRITEMASK [0]
  - 7 STENCIL_FUNC: front in [15:0], back in [31:16], each field LSB-aligned
  - 8 STENCIL_ZPASS: same front/back split
  - 9 STENCIL_ZFAIL: same front/back split
  - 10 STENCIL_FAIL: same front/back split
  - 11 STENCIL_REF: front [7:0], back [23:16]
  - 12 STENCIL_WRITEMASK: front [7:0], back [23:16]
  - 13 BLEND_MODE: rgb [15:0], a [31:16]
  - 14 BLEND_FUNC: src_rgb [7:0], src_a [15:8], dst_rgb [23:16], dst_a [31:24]
  - 15 BLEND_CONST: rgba_t, packed as a[31:24] r[23:16] g[15:8] b[7:0]
  - 16 LOGIC_OP
- Field truncation: upper unused bits of each field are dropped on write and read back as 0.
- Out-of-range writes (index > 16 or address < `DCR_BASE`) are accepted and ignored. Out-of-range reads return 0.
- Defaults, applied by reset to both the staged and active images:
  - `cbuf_mask` = 'hFFFFFFFF
  - depth/stencil funcs = `ROP_DEPTH_FUNC_ALWAYS`
  - stencil ops = `ROP_STENCIL_OP_KEEP`
  - stencil masks = 'hFF
  - blend modes = `ROP_BLEND_MODE_ADD`
  - src funcs = `ROP_BLEND_FUNC_ONE`, dst funcs = `ROP_BLEND_FUNC_ZERO`
  - `logic_op` = `ROP_LOGIC_OP_COPY`
  - everything else = 0
- FSM with states IDLE and PENDING:
  - IDLE, `commit`&`rop_idle`: copy staged→active at this edge; stay IDLE.
  - IDLE, `commit`&!`rop_idle`: go to PENDING.
  - PENDING, `rop_idle`: copy, then go to IDLE.
  - PENDING, `commit`: ignored; the request merges with the pending one.
- `dcr_wr_ready` = (state==IDLE). Staged registers are frozen while a commit is pending.
- Write and commit in the same cycle (IDLE): the copy uses the post-write staged value (write bypassed into the active image).
- `commit_pending` = (state==PENDING).

## Timing
- Reset values: `dcr_wr_ready`=1 the cycle after reset; `dcr_rd_data`=0; `dcrs`=defaults; `dcrs_changed`=0; `commit_pending`=0; state=IDLE.
- Write: an accepted write is visible in the staged image at the next edge. Readback of the same index in that next cycle returns the new value on the following cycle.
- Readback latency: 1 cycle, registered.
- Commit latency: `dcrs` updates at the edge where the copy occurs. `dcrs_changed` is high for exactly the following cycle.
- Reset asserted in PENDING: the pending commit is dropped and both images return to defaults.
- Throughput: one write per cycle in IDLE.

## Test plan
- Reset, then read index 2 and index 16 → `dcr_rd_data` = 'hFFFFFFFF, then `ROP_LOGIC_OP_COPY`; `dcrs` equals defaults; `dcrs_changed`=0.
- Write idx0='h8000_0000, commit with `rop_idle`=1 → `dcrs.cbuf_addr`='h8000_0000 next cycle; `dcrs_changed` pulses once.
- Write idx11='h00AB_00CD, commit with `rop_idle`=0 for 5 cycles, then raise it:
  - `commit_pending`=1 and `dcr_wr_ready`=0 during the wait; `dcrs` unchanged.
  - After the idle edge: `stencil_front_ref`='hCD, `stencil_back_ref`='hAB.
- Same-cycle write idx15='h11223344 with `commit`&`rop_idle` → `blend_const` = a 'h11, r 'h22, g 'h33, b 'h44 at that edge.
- Write to `DCR_BASE`+40 and to `DCR_BASE`-1 → no staged change; readback of both = 0.
- Assert `reset` while PENDING → `commit_pending`=0, `dcrs`=defaults, and no `dcrs_changed` pulse.
